// File: rtl/axi_pkg.sv
// Shared defaults and state type for the AXI write-data generator.
package axi_pkg;

  localparam int DEF_ID_MAX_WIDTH = 4;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_LEN_WIDTH    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_t;

endpackage

// File: rtl/axi_wr_data_gen_if.sv
// AXI W-channel bundle; master drives the beat, slave returns wready.
interface axi_wr_data_channel #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) ();

  logic                  wvalid;
  logic                  wready;
  logic [ID_W-1:0]       wid;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  modport master (
    output wvalid, wid, wdata, wstrb, wlast,
    input  wready
  );

  modport slave (
    input  wvalid, wid, wdata, wstrb, wlast,
    output wready
  );

endinterface

// File: rtl/axi_wr_data_gen.sv
// Turns a burst command plus a local beat stream into AXI W-channel beats
// through a single output register stage.
//
// state    | meaning
// ---------|--------------------------------------------------------
// ST_IDLE  | waiting for a burst command, local beats held off
// ST_BURST | moving local beats to W until the wlast beat handshakes
module axi_wr_data_gen
  import axi_pkg::*;
#(
  parameter int ID_MAX_WIDTH = DEF_ID_MAX_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ID_MAX_WIDTH-1:0]   cmd_id,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic [DATA_WIDTH/8-1:0]   s_strb,
  axi_wr_data_channel.master        w,
  output logic                      burst_done
);

  wr_state_t               state;
  wr_state_t               state_nxt;
  logic [ID_MAX_WIDTH-1:0] id_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    cnt;
  logic                    last_loaded;
  logic                    load;
  logic                    w_fire;
  logic                    cnt_at_len;

  assign load       = s_valid && s_ready;
  assign w_fire     = w.wvalid && w.wready;
  assign cnt_at_len = (cnt == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        // Refill the output register when it is empty or draining this cycle.
        s_ready = !last_loaded && (!w.wvalid || w.wready);
        if (w_fire && w.wlast) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q        <= '0;
      len_q       <= '0;
      cnt         <= '0;
      last_loaded <= 1'b0;
      burst_done  <= 1'b0;
      w.wvalid    <= 1'b0;
      w.wid       <= '0;
      w.wdata     <= '0;
      w.wstrb     <= '0;
      w.wlast     <= 1'b0;
    end else begin
      burst_done <= w_fire && w.wlast;
      if (cmd_valid && cmd_ready) begin
        id_q        <= cmd_id;
        len_q       <= cmd_len;
        cnt         <= '0;
        last_loaded <= 1'b0;
      end
      if (load) begin
        w.wvalid <= 1'b1;
        w.wid    <= id_q;
        w.wdata  <= s_data;
        w.wstrb  <= s_strb;
        w.wlast  <= cnt_at_len;
        cnt      <= cnt + 1'b1;
        // The counter may wrap after the final load; last_loaded blocks any further beats.
        if (cnt_at_len) begin
          last_loaded <= 1'b1;
        end
      end else if (w_fire) begin
        w.wvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_data_gen.sv
// Self-checking bench for axi_wr_data_gen: table-driven bursts with random
// gaps, a burst-level reference model, and hand sequences for stall and reset.
module tb_axi_wr_data_gen;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ID_W-1:0]     cmd_id;
  logic [LEN_W-1:0]    cmd_len;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic [DATA_W/8-1:0] s_strb;
  logic                burst_done;

  axi_wr_data_channel #(.ID_W(ID_W), .DATA_W(DATA_W)) w_if ();

  axi_wr_data_gen #(
    .ID_MAX_WIDTH(ID_W),
    .DATA_WIDTH  (DATA_W),
    .LEN_WIDTH   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_strb    (s_strb),
    .w         (w_if),
    .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [3:0]  id;
    logic [31:0] data_base;
    logic [3:0]  strb;
    int          s_pct;
    int          w_pct;
    int          exp_beats;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: burst-level view of what should be on the pins.
  bit          m_init = 0;
  bit          m_busy;
  int          m_len;
  logic [3:0]  m_id;
  int          m_acc;
  bit          m_out;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  bit          m_last;
  logic [3:0]  m_wid;
  int          m_beat_idx;
  bit          m_done;

  int          obs_beats;
  int          obs_lasts;
  int          obs_done;
  int          done_cyc;
  int          cmd_cyc;
  logic [31:0] first_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_s_ready();
    return m_busy && (m_acc <= m_len) && (!m_out || (w_if.wready == 1'b1));
  endfunction

  task automatic check_outputs();
    if (!m_init) return;
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
    chk("s_ready", 64'(s_ready), 64'(exp_s_ready()));
    chk("wvalid", 64'(w_if.wvalid), 64'(m_out));
    chk("burst_done", 64'(burst_done), 64'(m_done));
    if (m_out) begin
      chk("wid", 64'(w_if.wid), 64'(m_wid));
      chk("wdata", 64'(w_if.wdata), 64'(m_data));
      chk("wstrb", 64'(w_if.wstrb), 64'(m_strb));
      chk("wlast", 64'(w_if.wlast), 64'(m_last));
    end
  endtask

  task automatic model_step();
    bit sr, wf, nd;
    if (rst) begin
      m_init = 1; m_busy = 0; m_out = 0; m_done = 0; m_acc = 0; m_len = 0;
      m_data = '0; m_strb = '0; m_last = 0; m_wid = '0; m_id = '0; m_beat_idx = 0;
      return;
    end
    if (!m_init) return;
    sr = exp_s_ready();
    wf = m_out && (w_if.wready == 1'b1);
    nd = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1; m_id = cmd_id; m_len = int'(cmd_len); m_acc = 0;
      end
    end else begin
      if (wf && m_last) begin
        nd = 1; m_busy = 0;
      end
      if (s_valid && sr) begin
        m_out = 1; m_data = s_data; m_strb = s_strb; m_wid = m_id;
        m_last = (m_acc == m_len); m_beat_idx = m_acc; m_acc++;
      end else if (wf) begin
        m_out = 0;
      end
    end
    m_done = nd;
  endtask

  // Inputs are already driven just after a falling edge.
  task automatic cycle();
    #1;
    if (w_if.wvalid === 1'b1 && w_if.wready === 1'b1) begin
      obs_beats++;
      if (obs_beats == 1) first_data = w_if.wdata;
      if (w_if.wlast === 1'b1) obs_lasts++;
    end
    if (burst_done === 1'b1) begin
      obs_done++;
      done_cyc = cyc;
    end
    check_outputs();
    if (m_init && !rst && !m_busy && cmd_valid) cmd_cyc = cyc;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_obs();
    obs_beats = 0; obs_lasts = 0; obs_done = 0; done_cyc = 0; cmd_cyc = 0; first_data = '0;
  endtask

  task automatic run_burst(input vec_t r, input string tag);
    int  k = 0;
    bit  started = 0;
    bit  take;
    int  bound = 40 * (r.len + 1) + 40;
    clear_obs();
    for (int n = 0; n < bound; n++) begin
      if (!m_busy && !started) begin
        cmd_valid = 1'b1; cmd_id = r.id; cmd_len = LEN_W'(r.len);
      end else if (m_busy && m_acc <= m_len) begin
        cmd_valid = 1'b1; cmd_id = ~r.id; cmd_len = LEN_W'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      s_valid     = (int'($urandom_range(99, 0)) < r.s_pct);
      s_data      = r.data_base ^ 32'(k);
      s_strb      = r.strb ^ 4'(k);
      w_if.wready = (int'($urandom_range(99, 0)) < r.w_pct);
      take        = s_valid && exp_s_ready();
      if (!m_busy && cmd_valid) started = 1;
      cycle();
      if (take) k++;
      if (obs_done > 0) break;
    end
    chk({tag, "_done_seen"}, 64'(obs_done > 0), 64'(1));
    cmd_valid = 1'b0; s_valid = 1'b1; w_if.wready = 1'b1;
    cycle();
    s_valid = 1'b0;
    chk({tag, "_beats"}, 64'(obs_beats), 64'(r.exp_beats));
    chk({tag, "_wlast_count"}, 64'(obs_lasts), 64'(1));
    chk({tag, "_done_pulses"}, 64'(obs_done), 64'(1));
    chk({tag, "_first_data"}, 64'(first_data), 64'(r.data_base));
    if (r.exp_lat > 0) chk({tag, "_latency"}, 64'(done_cyc - cmd_cyc), 64'(r.exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          k;
    int          stall_left;
    int          stalls;
    bit          take;
    logic [31:0] beat2_data;

    //           len  id     data_base      strb  s%   w%  beats lat
    vecs[0] = '{   3, 4'd5,  32'h1000_0000, 4'hF, 100, 100,   4,  6};
    vecs[1] = '{   0, 4'd9,  32'hDEAD_BEEF, 4'hF, 100, 100,   1,  3};
    vecs[2] = '{   7, 4'd3,  32'h5A5A_0000, 4'h3, 100, 100,   8, 10};
    vecs[3] = '{ 255, 4'd12, 32'h0BAD_0000, 4'hC,  60,  60, 256,  0};
    vecs[4] = '{  15, 4'd0,  32'h7777_0000, 4'h1,  50, 100,  16,  0};
    vecs[5] = '{   5, 4'd15, 32'hC0DE_0000, 4'h8, 100,  40,   6,  0};
    vecs[6] = '{   1, 4'd7,  32'h2468_0000, 4'h6, 100, 100,   2,  4};

    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; s_strb = '0; w_if.wready = 1'b0;
    clear_obs();
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_wvalid", 64'(w_if.wvalid), 64'(0));
    chk("rst_wlast", 64'(w_if.wlast), 64'(0));
    chk("rst_wid", 64'(w_if.wid), 64'(0));
    chk("rst_wdata", 64'(w_if.wdata), 64'(0));
    chk("rst_wstrb", 64'(w_if.wstrb), 64'(0));
    chk("rst_burst_done", 64'(burst_done), 64'(0));

    for (int i = 0; i < 6; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // Stall beat 2 for three cycles with s_valid high.
    clear_obs();
    cmd_valid = 1'b1; cmd_id = 4'd2; cmd_len = 8'd3; s_valid = 1'b0; w_if.wready = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    k = 0; stall_left = 3; stalls = 0; beat2_data = 32'hA0 + 32'd1;
    for (int n = 0; n < 30; n++) begin
      s_valid = 1'b1;
      s_data  = 32'hA0 + 32'(k);
      s_strb  = 4'(k) ^ 4'hA;
      if (m_out && m_beat_idx == 1 && stall_left > 0) begin
        w_if.wready = 1'b0;
        stall_left--;
        #1;
        stalls++;
        chk("stall_wvalid", 64'(w_if.wvalid), 64'(1));
        chk("stall_wdata", 64'(w_if.wdata), 64'(beat2_data));
        chk("stall_s_ready", 64'(s_ready), 64'(0));
      end else begin
        w_if.wready = 1'b1;
      end
      take = s_valid && exp_s_ready();
      cycle();
      if (take) k++;
      if (obs_done > 0) break;
    end
    s_valid = 1'b0;
    chk("stall_cycles", 64'(stalls), 64'(3));
    chk("stall_beats", 64'(obs_beats), 64'(4));
    chk("stall_wlast_count", 64'(obs_lasts), 64'(1));
    chk("stall_done", 64'(obs_done), 64'(1));

    // Reset after two beats of an 8-beat burst, then a fresh 2-beat burst.
    clear_obs();
    cmd_valid = 1'b1; cmd_id = 4'd6; cmd_len = 8'd7; s_valid = 1'b0; w_if.wready = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    for (int n = 0; n < 20 && obs_beats < 2; n++) begin
      s_valid = 1'b1; s_data = 32'hB0 + 32'(n); s_strb = 4'hF; w_if.wready = 1'b1;
      cycle();
    end
    chk("abort_beats_before_rst", 64'(obs_beats), 64'(2));
    rst = 1'b1; s_valid = 1'b0;
    cycle();
    rst = 1'b0;
    #1;
    chk("abort_wvalid", 64'(w_if.wvalid), 64'(0));
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("abort_s_ready", 64'(s_ready), 64'(0));
    chk("abort_burst_done", 64'(burst_done), 64'(0));
    run_burst(vecs[6], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
